truth_table_scanner: RTL and testbench



---
 rtl/truth_table_scanner_if.sv | 26 ++
 rtl/truth_table_scanner.sv | 111 +++++++++++
 tb/tb_truth_table_scanner.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_scanner_if.sv
// rtl/truth_table_scanner_if.sv - stimulus/response and result bus between the scanner and its environment
interface truth_table_scanner_if #(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 3
) ();
  logic                 start;
  logic [WIDTH_IN-1:0]  vec_out;
  logic [WIDTH_OUT-1:0] resp_in;
  logic [WIDTH_OUT-1:0] exp_in;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [WIDTH_IN:0]    err_cnt;
  logic [WIDTH_IN-1:0]  first_fail_vec;
  logic [WIDTH_OUT-1:0] first_fail_resp;

  modport master (
    output start, resp_in, exp_in,
    input  vec_out, busy, done, pass, err_cnt, first_fail_vec, first_fail_resp
  );

  modport slave (
    input  start, resp_in, exp_in,
    output vec_out, busy, done, pass, err_cnt, first_fail_vec, first_fail_resp
  );
endinterface

// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - exhaustive input sweep with golden-model compare and mismatch report
// Optional: SCAN_STOP_ON_FAIL_EN ends the scan at the first mismatching vector.
module truth_table_scanner #(
  parameter int WIDTH_IN      = 8,
  parameter int WIDTH_OUT     = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_scanner_if.slave  bus
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] COMPARE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]           state;
  logic [CW-1:0]        settle_cnt;
  logic [WIDTH_IN-1:0]  vec_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 pass_q;
  logic [WIDTH_IN:0]    err_q;
  logic [WIDTH_IN-1:0]  ffv_q;
  logic [WIDTH_OUT-1:0] ffr_q;

  logic                 mismatch;
  logic                 last_vec;
  logic                 stop;
  logic [WIDTH_IN:0]    err_next;

  assign mismatch = (bus.resp_in != bus.exp_in);
  assign last_vec = &vec_q;
  assign err_next = err_q + {{WIDTH_IN{1'b0}}, mismatch};

`ifdef SCAN_STOP_ON_FAIL_EN
  // Only the first mismatch is ever seen, so stopping on any mismatch is stopping on the first.
  assign stop = last_vec | mismatch;
`else
  assign stop = last_vec;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      vec_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      ffv_q      <= '0;
      ffr_q      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // DONE holds results until a new launch; start is ignored while busy.
          if (bus.start) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            vec_q      <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            ffv_q      <= '0;
            ffr_q      <= '0;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= COMPARE;
          end else begin
            settle_cnt <= settle_cnt + CW'(1);
          end
        end
        COMPARE: begin
          err_q <= err_next;
          if (mismatch && (err_q == '0)) begin
            ffv_q <= vec_q;
            ffr_q <= bus.resp_in;
          end
          if (stop) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (err_next == '0);
          end else begin
            state      <= SETTLE;
            vec_q      <= vec_q + WIDTH_IN'(1);
            settle_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.vec_out         = vec_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.err_cnt         = err_q;
  assign bus.first_fail_vec  = ffv_q;
  assign bus.first_fail_resp = ffr_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb/tb_truth_table_scanner.sv - scoreboard bench for truth_table_scanner
module tb_truth_table_scanner;
  localparam int WI = 8;
  localparam int WO = 3;

  typedef struct {
    int launch;
    int cycles;
    int err;
    int ffv;
    int ffr;
    int pass;
    int vec;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  truth_table_scanner_if #(.WIDTH_IN(WI), .WIDTH_OUT(WO)) bus ();

  truth_table_scanner #(.WIDTH_IN(WI), .WIDTH_OUT(WO), .SETTLE_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int        checks   = 0;
  int        failures = 0;
  int        cyc      = 0;
  int        mode     = 0;
  logic [7:0] fail_vec = 8'h5A;
  exp_t      q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Function under test: golden is vec[7:5]^vec[2:0]; modes inject faults.
  logic [2:0] gold;
  always_comb begin
    gold = bus.vec_out[7:5] ^ bus.vec_out[2:0];
    bus.exp_in  = gold;
    bus.resp_in = gold;
    case (mode)
      1: bus.resp_in = gold ^ ((bus.vec_out == fail_vec) ? 3'b100 : 3'b000);
      2: begin
        bus.exp_in  = 3'b001;
        bus.resp_in = 3'b000;
      end
      default: ;
    endcase
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
    end
  endtask

  function automatic exp_t mk(input int cycles, input int err, input int ffv,
                              input int ffr, input int pass, input int vec);
    exp_t e;
    e.launch = 0; e.cycles = cycles; e.err = err; e.ffv = ffv;
    e.ffr = ffr; e.pass = pass; e.vec = vec;
    return e;
  endfunction

  // Monitor: every rising done pops one expected result.
  initial begin
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done && !done_prev) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_done: got done=1 expected no pending scan");
        end else begin
          e = q.pop_front();
          chk("done_latency", cyc - e.launch, e.cycles);
          chk("err_cnt", int'(bus.err_cnt), e.err);
          chk("first_fail_vec", int'(bus.first_fail_vec), e.ffv);
          chk("first_fail_resp", int'(bus.first_fail_resp), e.ffr);
          chk("pass", int'(bus.pass), e.pass);
          chk("vec_out_final", int'(bus.vec_out), e.vec);
          chk("busy_at_done", int'(bus.busy), 0);
        end
      end
      done_prev = bus.done;
    end
  end

  task automatic launch(input exp_t e, input int hold, input bit push);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    e.launch = cyc;
    if (push) q.push_back(e);
    repeat (hold) @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    if (!seen) chk("wait_done_timeout", 0, 1);
  endtask

  initial begin
    bit hit;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_pass", int'(bus.pass), 0);
    chk("rst_err_cnt", int'(bus.err_cnt), 0);
    chk("rst_vec_out", int'(bus.vec_out), 0);
    chk("rst_ffv", int'(bus.first_fail_vec), 0);
    chk("rst_ffr", int'(bus.first_fail_resp), 0);
    rst = 1'b0;

    // Clean sweep.
    mode = 0;
    launch(mk(768, 0, 0, 0, 1, 8'hFF), 0, 1'b1);
    wait_done();

    // Single fault at 0x5A on bit 2 (golden there is 000).
    mode = 1; fail_vec = 8'h5A;
`ifdef SCAN_STOP_ON_FAIL_EN
    launch(mk(273, 1, 8'h5A, 3'b100, 0, 8'h5A), 0, 1'b1);
`else
    launch(mk(768, 1, 8'h5A, 3'b100, 0, 8'hFF), 0, 1'b1);
`endif
    wait_done();

    // Every vector mismatches.
    mode = 2;
`ifdef SCAN_STOP_ON_FAIL_EN
    launch(mk(3, 1, 0, 0, 0, 0), 0, 1'b1);
`else
    launch(mk(768, 256, 0, 0, 0, 8'hFF), 0, 1'b1);
`endif
    wait_done();

    // Reset mid-scan at vector 0x40.
    mode = 0;
    launch(mk(0, 0, 0, 0, 0, 0), 0, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(negedge clk);
      if (bus.vec_out == 8'h40) hit = 1'b1;
    end
    chk("reach_vec_40", int'(hit), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_vec_out", int'(bus.vec_out), 0);
    chk("midrst_err_cnt", int'(bus.err_cnt), 0);
    chk("midrst_done", int'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;
    launch(mk(768, 0, 0, 0, 1, 8'hFF), 0, 1'b1);
    wait_done();

    // Long start pulse plus a mid-scan pulse must not restart.
    mode = 1; fail_vec = 8'h5A;
`ifdef SCAN_STOP_ON_FAIL_EN
    launch(mk(273, 1, 8'h5A, 3'b100, 0, 8'h5A), 5, 1'b1);
`else
    launch(mk(768, 1, 8'h5A, 3'b100, 0, 8'hFF), 5, 1'b1);
`endif
    repeat (100) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // Relaunch from DONE clears results on the accepting edge.
    mode = 0;
    launch(mk(768, 0, 0, 0, 1, 8'hFF), 0, 1'b1);
    chk("relaunch_done", int'(bus.done), 0);
    chk("relaunch_err_cnt", int'(bus.err_cnt), 0);
    chk("relaunch_busy", int'(bus.busy), 1);
    wait_done();

`ifdef SCAN_STOP_ON_FAIL_EN
    mode = 1; fail_vec = 8'h10;
    launch(mk(51, 1, 8'h10, 3'b100, 0, 8'h10), 0, 1'b1);
    wait_done();
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
